nn_layer_sequencer: RTL

Avalon-MM slave controller that sequences the neural-network processing units layer by layer. The HPS programs a unit mask, layer count and timeout, then writes start. The block pulses start to the selected units and collects their done strobes (the same 7-bit done vector the HPS otherwise polls through the done PIO). It advances the layer index until all layers finish, a timeout fires, or software aborts. It sits in the Qsys system between the HPS lightweight bridge and the accelerator units.

---
 rtl/nn_layer_sequencer_if.sv | 19 +
 rtl/nn_layer_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Avalon-MM register port of the NN layer sequencer.
// The HPS lightweight bridge is the master; the sequencer is the slave.
interface nn_layer_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Layer-by-layer start/done sequencer for the NN processing units.
// Define NN_LAYER_SEQ_IRQ_EN to add the sticky irq output and CTRL irq bits.
module nn_layer_sequencer #(
    parameter int NUM_UNITS = 7,
    parameter int LAYER_W   = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    nn_layer_sequencer_if.slave  avs,
    input  logic [NUM_UNITS-1:0] done_in,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [LAYER_W-1:0]   layer_idx,
    output logic                 busy
`ifdef NN_LAYER_SEQ_IRQ_EN
    ,
    output logic                 irq
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_UNITS-1:0] mask_q, mask_d;
    logic [LAYER_W-1:0]   nl_q, nl_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [NUM_UNITS-1:0] seen_q, seen_d;
    logic [NUM_UNITS-1:0] done_in_q;
    logic                 dflag_q, dflag_d;
    logic                 terr_q, terr_d;
    logic                 abrt_q, abrt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 wr, wr_ctrl, idle;
    logic                 start_req, abort_req;
    logic [NUM_UNITS-1:0] edges;
    logic                 unused_wd;

    assign wr        = avs.chipselect & ~avs.write_n;
    assign wr_ctrl   = wr & (avs.address == 2'd0);
    assign abort_req = wr_ctrl & avs.writedata[1];
    assign start_req = wr_ctrl & avs.writedata[0] & ~avs.writedata[1];
    assign idle      = (state_q == S_IDLE);
    // Only rising edges count, so a level held from a previous layer is ignored.
    assign edges     = done_in & ~done_in_q & mask_q;
    assign unused_wd = ^avs.writedata;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        nl_d       = nl_q;
        tmo_d      = tmo_q;
        timer_d    = timer_q;
        layer_d    = layer_q;
        seen_d     = seen_q;
        dflag_d    = dflag_q;
        terr_d     = terr_q;
        abrt_d     = abrt_q;
        unit_start = '0;
        if (idle && wr && avs.address == 2'd1) begin
            mask_d = avs.writedata[NUM_UNITS-1:0];
            nl_d   = avs.writedata[8 +: LAYER_W];
        end
        if (idle && wr && avs.address == 2'd3) begin
            tmo_d = avs.writedata[TIMEOUT_W-1:0];
        end
        if (abort_req && !idle) begin
            state_d = S_IDLE;
            abrt_d  = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        if (mask_q != '0 && nl_q != '0) begin
                            dflag_d = 1'b0;
                            terr_d  = 1'b0;
                            abrt_d  = 1'b0;
                            seen_d  = '0;
                            layer_d = '0;
                            state_d = S_LAUNCH;
                        end else begin
                            dflag_d = 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    unit_start = mask_q;
                    timer_d    = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    seen_d  = seen_q | edges;
                    timer_d = timer_q + TIMEOUT_W'(1);
                    if ((seen_q | edges) == mask_q) begin
                        state_d = S_NEXT;
                    end else if (tmo_q != '0 &&
                                 timer_q == tmo_q - TIMEOUT_W'(1)) begin
                        state_d = S_ERROR;
                    end
                end
                S_NEXT: begin
                    if (layer_q == nl_q - LAYER_W'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        layer_d = layer_q + LAYER_W'(1);
                        seen_d  = '0;
                        state_d = S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    dflag_d = 1'b1;
                    state_d = S_IDLE;
                end
                S_ERROR: begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            nl_q      <= '0;
            tmo_q     <= '0;
            timer_q   <= '0;
            layer_q   <= '0;
            seen_q    <= '0;
            done_in_q <= '0;
            dflag_q   <= 1'b0;
            terr_q    <= 1'b0;
            abrt_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            nl_q      <= nl_d;
            tmo_q     <= tmo_d;
            timer_q   <= timer_d;
            layer_q   <= layer_d;
            seen_q    <= seen_d;
            done_in_q <= done_in;
            dflag_q   <= dflag_d;
            terr_q    <= terr_d;
            abrt_q    <= abrt_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef NN_LAYER_SEQ_IRQ_EN
    logic irq_en_q, irq_q, irq_set;

    assign irq_set = irq_en_q &&
                     (state_d == S_FINISH || state_d == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en_q <= avs.writedata[2];
            if (irq_set) irq_q <= 1'b1;
            else if (wr_ctrl && avs.writedata[3]) irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        rdata_d = '0;
        unique case (avs.address)
            2'd0: begin
                rdata_d[0] = ~idle;
`ifdef NN_LAYER_SEQ_IRQ_EN
                rdata_d[2] = irq_en_q;
                rdata_d[3] = irq_q;
`endif
            end
            2'd1: begin
                rdata_d[NUM_UNITS-1:0] = mask_q;
                rdata_d[8 +: LAYER_W]  = nl_q;
            end
            2'd2: begin
                rdata_d[2:0]            = state_q;
                rdata_d[3]              = dflag_q;
                rdata_d[4]              = terr_q;
                rdata_d[5]              = abrt_q;
                rdata_d[8 +: LAYER_W]   = layer_q;
                rdata_d[16 +: NUM_UNITS] = seen_q;
            end
            2'd3: rdata_d[TIMEOUT_W-1:0] = tmo_q;
        endcase
    end

    assign avs.readdata = rdata_q;
    assign layer_idx    = layer_q;
    assign busy         = ~idle;

endmodule
